game_countdown_timer: RTL and testbench

Countdown timer that sits directly upstream of the game state machine. It watches the machine's `game_active` output and, on each new game, counts `GAME_SECONDS` whole seconds down to zero from the 100 MHz clock. At zero it raises a one-cycle `timer_expired` pulse that ends the round. It also drives the remaining time as two BCD digits for the seven-segment display path.

---
 rtl/game_countdown_timer_if.sv | 28 ++
 rtl/game_countdown_timer.sv | 105 ++++++++++
 tb/tb_game_countdown_timer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/game_countdown_timer_if.sv
// Signal bundle between the game FSM and the countdown timer.
// The timer side uses the master modport, the game/display side uses slave.
interface game_countdown_timer_if;
    logic       game_active;
    logic       timer_expired;
    logic       tick_1hz;
    logic [6:0] seconds_left;
    logic [3:0] secs_tens;
    logic [3:0] secs_ones;

    modport master (
        input  game_active,
        output timer_expired,
        output tick_1hz,
        output seconds_left,
        output secs_tens,
        output secs_ones
    );

    modport slave (
        output game_active,
        input  timer_expired,
        input  tick_1hz,
        input  seconds_left,
        input  secs_tens,
        input  secs_ones
    );
endinterface

// File: rtl/game_countdown_timer.sv
// Round countdown timer for the game FSM.
// Counts GAME_SECONDS whole seconds down from the system clock once a round
// starts, pulses timer_expired at zero, and keeps a BCD copy of the
// remaining time for the seven-segment display.
module game_countdown_timer #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int GAME_SECONDS = 30
) (
    input  logic                  clkIn,
    input  logic                  reset,
    game_countdown_timer_if.master bus
);

    localparam int          PW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [6:0]  LOAD_SECS = 7'(GAME_SECONDS);
    localparam logic [3:0]  LOAD_TENS = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]  LOAD_ONES = 4'(GAME_SECONDS % 10);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [6:0]    seconds_q;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic          expired_q;
    logic          tick_q;

    // Round FSM: prescaler, binary and BCD countdown, and one-cycle pulses, all registered.
    always_ff @(posedge clkIn) begin
        if (reset) begin
            state     <= IDLE;
            prescaler <= '0;
            seconds_q <= LOAD_SECS;
            tens_q    <= LOAD_TENS;
            ones_q    <= LOAD_ONES;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.game_active) begin
                        state     <= COUNT;
                        prescaler <= '0;
                        seconds_q <= LOAD_SECS;
                        tens_q    <= LOAD_TENS;
                        ones_q    <= LOAD_ONES;
                    end
                end
                COUNT: begin
                    if (!bus.game_active) begin
                        state     <= IDLE;
                        prescaler <= '0;
                    end else if (prescaler == PRE_MAX) begin
                        prescaler <= '0;
                        tick_q    <= 1'b1;
                        if (seconds_q <= 7'd1) begin
                            seconds_q <= 7'd0;
                            tens_q    <= 4'd0;
                            ones_q    <= 4'd0;
                            expired_q <= 1'b1;
                            state     <= DONE;
                        end else begin
                            seconds_q <= seconds_q - 7'd1;
                            if (ones_q == 4'd0) begin
                                ones_q <= 4'd9;
                                tens_q <= tens_q - 4'd1;
                            end else begin
                                ones_q <= ones_q - 4'd1;
                            end
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end
                DONE: begin
                    if (!bus.game_active) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    prescaler <= '0;
                end
            endcase
        end
    end

    // Drive the registered values onto the interface.
    always_comb begin
        bus.timer_expired = expired_q;
        bus.tick_1hz      = tick_q;
        bus.seconds_left  = seconds_q;
        bus.secs_tens     = tens_q;
        bus.secs_ones     = ones_q;
    end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer.
// dut1 runs CLK_HZ=4, GAME_SECONDS=3; dut2 runs GAME_SECONDS=12 for the BCD borrow.
module tb_game_countdown_timer;

    logic clkIn;
    logic reset;
    int   total;
    int   bad;

    game_countdown_timer_if bus1 ();
    game_countdown_timer_if bus2 ();

    game_countdown_timer #(.CLK_HZ(4), .GAME_SECONDS(3)) dut1 (
        .clkIn (clkIn),
        .reset (reset),
        .bus   (bus1)
    );

    game_countdown_timer #(.CLK_HZ(4), .GAME_SECONDS(12)) dut2 (
        .clkIn (clkIn),
        .reset (reset),
        .bus   (bus2)
    );

    // 10 ns system clock.
    initial begin
        clkIn = 1'b0;
        forever #5 clkIn = ~clkIn;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Checks all dut1 outputs against the three-second round model for cycles k=0..ncyc-1,
    // where k=0 is the cycle right after the start edge S.
    task automatic run_round(input int ncyc);
        int exp_secs;
        int exp_tick;
        int exp_exp;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clkIn);
            exp_secs = (k >= 12) ? 0 : 3 - (k / 4);
            exp_tick = (k > 0 && k <= 12 && (k % 4) == 0) ? 1 : 0;
            exp_exp  = (k == 12) ? 1 : 0;
            check_output("round_secs", int'(bus1.seconds_left), exp_secs);
            check_output("round_tens", int'(bus1.secs_tens), exp_secs / 10);
            check_output("round_ones", int'(bus1.secs_ones), exp_secs % 10);
            check_output("round_tick", int'(bus1.tick_1hz), exp_tick);
            check_output("round_expired", int'(bus1.timer_expired), exp_exp);
        end
    endtask

    // Checks that dut1 is frozen at a value with no pulses for n cycles.
    task automatic check_quiet(input int n, input int secs);
        for (int k = 0; k < n; k++) begin
            @(negedge clkIn);
            check_output("quiet_secs", int'(bus1.seconds_left), secs);
            check_output("quiet_tick", int'(bus1.tick_1hz), 0);
            check_output("quiet_expired", int'(bus1.timer_expired), 0);
        end
    endtask

    initial begin
        int exp2;
        total            = 0;
        bad              = 0;
        reset            = 1'b1;
        bus1.game_active = 1'b0;
        bus2.game_active = 1'b0;
        repeat (3) @(negedge clkIn);

        // Reset values with game_active low.
        check_output("rst_secs", int'(bus1.seconds_left), 3);
        check_output("rst_tens", int'(bus1.secs_tens), 0);
        check_output("rst_ones", int'(bus1.secs_ones), 3);
        check_output("rst_expired", int'(bus1.timer_expired), 0);
        check_output("rst_tick", int'(bus1.tick_1hz), 0);
        check_output("rst2_tens", int'(bus2.secs_tens), 1);
        check_output("rst2_ones", int'(bus2.secs_ones), 2);
        reset = 1'b0;
        check_quiet(3, 3);

        // Full round, then held high in DONE for 10 cycles.
        $display("[TB] full round");
        bus1.game_active = 1'b1;
        run_round(13);
        check_quiet(10, 0);

        // One-cycle drop then re-rise starts a fresh round.
        bus1.game_active = 1'b0;
        check_quiet(1, 0);
        bus1.game_active = 1'b1;
        run_round(14);
        bus1.game_active = 1'b0;
        check_quiet(2, 0);

        // Abort at S+6: value freezes at 2, then a restart reloads and re-times.
        $display("[TB] abort mid-second");
        bus1.game_active = 1'b1;
        run_round(6);
        bus1.game_active = 1'b0;
        check_quiet(6, 2);
        bus1.game_active = 1'b1;
        run_round(13);
        bus1.game_active = 1'b0;
        check_quiet(2, 0);

        // Abort on the same edge as a wrap: no decrement, no tick.
        $display("[TB] abort on wrap edge");
        bus1.game_active = 1'b1;
        run_round(4);
        bus1.game_active = 1'b0;
        check_quiet(3, 3);

        // Reset on the S+8 decrement edge, game_active held: restart on next edge.
        $display("[TB] reset on decrement edge");
        bus1.game_active = 1'b1;
        run_round(8);
        reset = 1'b1;
        @(negedge clkIn);
        check_output("rstmid_secs", int'(bus1.seconds_left), 3);
        check_output("rstmid_tick", int'(bus1.tick_1hz), 0);
        check_output("rstmid_expired", int'(bus1.timer_expired), 0);
        reset = 1'b0;
        run_round(13);
        bus1.game_active = 1'b0;
        check_quiet(2, 0);

        // Twelve-second round on dut2: BCD borrow on 10 -> 9 and digit consistency.
        $display("[TB] bcd borrow");
        bus2.game_active = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clkIn);
            exp2 = (k >= 48) ? 0 : 12 - (k / 4);
            check_output("bcd_secs", int'(bus2.seconds_left), exp2);
            check_output("bcd_tens", int'(bus2.secs_tens), exp2 / 10);
            check_output("bcd_ones", int'(bus2.secs_ones), exp2 % 10);
            check_output("bcd_expired", int'(bus2.timer_expired), (k == 48) ? 1 : 0);
        end
        bus2.game_active = 1'b0;
        @(negedge clkIn);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
